// File: rtl/bt_pkg.sv
// rtl/bt_pkg.sv - shared ASCII constants and FSM state encoding for the BT command parser
package bt_pkg;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CMD_L   = 8'h4C;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_T   = 8'h54;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] HI   = 3'd2;
    localparam logic [2:0] LO   = 3'd3;
    localparam logic [2:0] END  = 3'd4;

endpackage

// File: rtl/bt_hex2nib.sv
// rtl/bt_hex2nib.sv - combinational ASCII hex digit to nibble decoder
module bt_hex2nib (
    input  logic [7:0] ascii,
    output logic [3:0] nib,
    output logic       is_hex
);

    always_comb begin
        nib    = 4'h0;
        is_hex = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nib    = ascii[3:0];
            is_hex = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            nib    = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/bt_cmd_parser.sv
// rtl/bt_cmd_parser.sv - ASCII command frame parser driving a 16-bit LED register
module bt_cmd_parser
    import bt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk_10Hz,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] led,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [7:0]  err_cnt
);

    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [3:0]    hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [15:0]   led_q, led_d;
    logic          done_q, done_d, err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [3:0] nib;
    logic       is_hex;
    logic [7:0] arg;
    logic       is_hash, is_term, is_cmd, timeout;

    bt_hex2nib u_hex2nib (
        .ascii  (rx_data),
        .nib    (nib),
        .is_hex (is_hex)
    );

    assign arg     = {hi_q, lo_q};
    assign is_hash = (rx_data == CH_HASH);
    assign is_term = (rx_data == CH_LF) || (rx_data == CH_CR);
    assign is_cmd  = (rx_data == CMD_L) || (rx_data == CMD_H) || (rx_data == CMD_T);
    // an arriving byte always beats an expiring timer
    assign timeout = (state_q != IDLE) && !rx_valid && (tmo_q == TO_LAST);

    always_ff @(posedge clk_10Hz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                IDLE:    state_d = is_hash ? CMD : IDLE;
                CMD:     state_d = is_cmd ? HI : (is_hash ? CMD : IDLE);
                HI:      state_d = is_hex ? LO : (is_hash ? CMD : IDLE);
                LO:      state_d = is_hex ? END : (is_hash ? CMD : IDLE);
                END:     state_d = is_hash ? CMD : IDLE;
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cmd_d  = cmd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        led_d  = led_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        tmo_d  = (rx_valid || state_q == IDLE || timeout) ? '0 : tmo_q + CW'(1);
        if (rx_valid) begin
            case (state_q)
                CMD: begin
                    if (is_cmd)        cmd_d = rx_data;
                    else if (!is_hash) err_d = 1'b1;
                end
                HI: begin
                    if (is_hex) hi_d  = nib;
                    else        err_d = 1'b1;
                end
                LO: begin
                    if (is_hex) lo_d  = nib;
                    else        err_d = 1'b1;
                end
                END: begin
                    if (!is_term) begin
                        err_d = 1'b1;
                    end else if (cmd_q == CMD_L) begin
                        led_d[7:0] = arg;
                        done_d     = 1'b1;
                    end else if (cmd_q == CMD_H) begin
                        led_d[15:8] = arg;
                        done_d      = 1'b1;
                    end else if (cmd_q == CMD_T && arg[7:4] == 4'h0) begin
                        led_d[arg[3:0]] = ~led_q[arg[3:0]];
                        done_d          = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            err_d = 1'b1;
        end
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_10Hz or negedge reset) begin
        if (!reset) begin
            cmd_q     <= 8'h00;
            hi_q      <= 4'h0;
            lo_q      <= 4'h0;
            tmo_q     <= '0;
            led_q     <= 16'h0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            cmd_q     <= cmd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            tmo_q     <= tmo_d;
            led_q     <= led_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign led      = led_q;
    assign cmd_done = done_q;
    assign cmd_err  = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// tb/tb_bt_cmd_parser.sv - directed self-checking bench for bt_cmd_parser
module tb_bt_cmd_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] led;
    logic        cmd_done;
    logic        cmd_err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_pulses = 0;
    int both_cnt = 0;
    logic last_done, last_err;

    bt_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
        .clk_10Hz (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .led      (led),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err),
        .err_cnt  (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    always @(negedge clk) begin
        if (cmd_done) done_cnt++;
        if (cmd_err) err_pulses++;
        if (cmd_done && cmd_err) both_cnt++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // byte is captured on the next posedge; outputs are read half a cycle later
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h23;
        last_done = cmd_done;
        last_err  = cmd_err;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        idle(3);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_gap(b0); send_gap(b1); send_gap(b2); send_gap(b3); send_byte(b4);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({led, cmd_done, cmd_err, err_cnt} !== 26'h0) begin
            fails++;
            $display("FAIL reset_state: led=%h done=%b err=%b err_cnt=%0d, want all 0", led, cmd_done, cmd_err, err_cnt);
        end
    endtask

    task automatic test_load();
        int d0, e0;
        d0 = done_cnt; e0 = err_pulses;
        send_frame(8'h23, 8'h4C, 8'h41, 8'h35, 8'h0A);
        tests++;
        if (last_done !== 1'b1 || led !== 16'h00A5) begin
            fails++;
            $display("FAIL load_l: done=%b led=%h, want 1 00a5", last_done, led);
        end
        idle(1);
        tests++;
        if (cmd_done !== 1'b0) begin
            fails++;
            $display("FAIL done_width: cmd_done=%b one cycle later, want 0", cmd_done);
        end
        idle(2);
        send_frame(8'h23, 8'h48, 8'h63, 8'h33, 8'h0D);
        idle(3);
        tests++;
        if (led !== 16'hC3A5) begin
            fails++;
            $display("FAIL load_h: led=%h, want c3a5", led);
        end
        // CR LF pair: trailing LF lands in IDLE and is ignored
        send_frame(8'h23, 8'h4C, 8'h33, 8'h34, 8'h0D);
        send_gap(8'h0A);
        tests++;
        if (led !== 16'hC334 || done_cnt - d0 !== 3 || err_pulses - e0 !== 0 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL load_crlf: led=%h done=%0d err=%0d err_cnt=%0d, want c334 3 0 0",
                     led, done_cnt - d0, err_pulses - e0, err_cnt);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        send_frame(8'h23, 8'h54, 8'h30, 8'h37, 8'h0A);
        idle(3);
        tests++;
        if (led !== 16'h0080) begin
            fails++;
            $display("FAIL toggle_set: led=%h, want 0080", led);
        end
        send_frame(8'h23, 8'h54, 8'h30, 8'h37, 8'h0A);
        idle(3);
        tests++;
        if (led !== 16'h0000) begin
            fails++;
            $display("FAIL toggle_clr: led=%h, want 0000", led);
        end
        send_frame(8'h23, 8'h54, 8'h31, 8'h30, 8'h0A);
        tests++;
        if (last_err !== 1'b1 || last_done !== 1'b0 || err_cnt !== 8'd1 || led !== 16'h0000) begin
            fails++;
            $display("FAIL toggle_range: err=%b done=%b err_cnt=%0d led=%h, want 1 0 1 0000",
                     last_err, last_done, err_cnt, led);
        end
        idle(3);
    endtask

    task automatic test_resync();
        int d0, e0;
        send_gap(8'h23); send_gap(8'h4C); send_byte(8'h47);
        tests++;
        if (last_err !== 1'b1 || err_cnt !== 8'd2) begin
            fails++;
            $display("FAIL bad_hex: err=%b err_cnt=%0d, want 1 2", last_err, err_cnt);
        end
        idle(3);
        d0 = done_cnt; e0 = err_pulses;
        send_gap(8'h30); send_gap(8'h31); send_gap(8'h0A);
        tests++;
        if (done_cnt - d0 !== 0 || err_pulses - e0 !== 0 || led !== 16'h0000) begin
            fails++;
            $display("FAIL idle_ignore: done=%0d err=%0d led=%h, want 0 0 0000", done_cnt - d0, err_pulses - e0, led);
        end
        d0 = done_cnt; e0 = err_pulses;
        send_gap(8'h23); send_gap(8'h4C); send_gap(8'h23);
        send_frame(8'h4C, 8'h30, 8'h31, 8'h0A, 8'h0A);
        idle(3);
        tests++;
        if (done_cnt - d0 !== 1 || err_pulses - e0 !== 1 || led !== 16'h0001 || err_cnt !== 8'd3) begin
            fails++;
            $display("FAIL resync: done=%0d err=%0d led=%h err_cnt=%0d, want 1 1 0001 3",
                     done_cnt - d0, err_pulses - e0, led, err_cnt);
        end
    endtask

    task automatic test_timeout();
        int k, d0;
        do_reset();
        send_gap(8'h23);
        send_byte(8'h4C);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cmd_err) begin k = i; break; end
        end
        tests++;
        if (k !== 100 || err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL timeout: err after %0d cycles err_cnt=%0d, want 100 1", k, err_cnt);
        end
        idle(3);
        d0 = done_cnt;
        send_gap(8'h30); send_gap(8'h31); send_gap(8'h0A);
        tests++;
        if (led !== 16'h0000 || done_cnt - d0 !== 0 || err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL post_timeout: led=%h done=%0d err_cnt=%0d, want 0000 0 1", led, done_cnt - d0, err_cnt);
        end
    endtask

    task automatic test_byte_wins();
        int e0;
        e0 = err_pulses;
        send_gap(8'h23);
        send_byte(8'h4C);
        idle(99);
        send_gap(8'h30);
        send_gap(8'h31);
        send_gap(8'h0A);
        tests++;
        if (led !== 16'h0001 || err_pulses - e0 !== 0 || err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL byte_wins: led=%h err=%0d err_cnt=%0d, want 0001 0 1", led, err_pulses - e0, err_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        send_frame(8'h23, 8'h4C, 8'h35, 8'h41, 8'h0A);
        idle(2);
        for (int i = 0; i < 254; i++) begin
            send_gap(8'h23); send_gap(8'h5A);
        end
        tests++;
        if (err_cnt !== 8'd254) begin
            fails++;
            $display("FAIL err_cnt_254: err_cnt=%0d, want 254", err_cnt);
        end
        for (int i = 0; i < 46; i++) begin
            send_gap(8'h23); send_gap(8'h5A);
        end
        tests++;
        if (err_cnt !== 8'd255 || led !== 16'h005A) begin
            fails++;
            $display("FAIL err_cnt_sat: err_cnt=%0d led=%h, want 255 005a", err_cnt, led);
        end
    endtask

    task automatic test_reset_midframe();
        send_gap(8'h23); send_gap(8'h4C); send_byte(8'h5A);
        #10;
        reset = 1'b0;
        #1;
        tests++;
        if ({led, cmd_done, cmd_err, err_cnt} !== 26'h0) begin
            fails++;
            $display("FAIL async_reset: led=%h done=%b err=%b err_cnt=%0d, want all 0", led, cmd_done, cmd_err, err_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        send_frame(8'h23, 8'h48, 8'h31, 8'h32, 8'h0D);
        tests++;
        if (last_done !== 1'b1 || led !== 16'h1200 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL after_reset: done=%b led=%h err_cnt=%0d, want 1 1200 0", last_done, led, err_cnt);
        end
        idle(3);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        last_done = 1'b0;
        last_err  = 1'b0;
        test_reset();
        test_load();
        test_toggle();
        test_resync();
        test_timeout();
        test_byte_wins();
        test_saturate();
        test_reset_midframe();
        tests++;
        if (both_cnt !== 0) begin
            fails++;
            $display("FAIL done_err_overlap: %0d cycles with both set, want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bt_cmd_parser.md
# bt_cmd_parser

Command parser directly downstream of the Bluetooth UART Rx decoder. It consumes decoded 8-bit bytes, each qualified by a one-cycle strobe, and assembles ASCII command frames. Valid commands update a 16-bit LED register; malformed frames are rejected, and stalled frames are dropped after a timeout. Runs in the 10 MHz domain shared with the Rx decoder.

## Interface
- TIMEOUT_CYCLES, 10_000_000, inter-byte timeout in clock cycles while a frame is open (1 s at 10 MHz); must be ≥ 2
- clk_10Hz  input  1  10 MHz system clock (period 100 ns)
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  decoded UART byte; sampled only when rx_valid=1
- rx_valid  input  1  one-cycle strobe, byte available; at least 1040 cycles between strobes at 9600 baud
- led  output  16  LED register; reset 16'h0000
- cmd_done  output  1  one-cycle pulse, command executed; reset 0
- cmd_err  output  1  one-cycle pulse, frame rejected or timed out; reset 0
- err_cnt  output  8  saturating error count (sticks at 255); reset 0

## Operation
- Frame format is 5 bytes: '#'(0x23), CMD, HEX_HI, HEX_LO, terminator LF(0x0A) or CR(0x0D).
- Hex digits are '0'-'9', 'A'-'F' and 'a'-'f'. arg = {HEX_HI, HEX_LO} nibbles.
- Commands:
  - 'L': led[7:0] <= arg.
  - 'H': led[15:8] <= arg.
  - 'T': led[arg[3:0]] toggles. Requires arg ≤ 8'h0F; otherwise it is an error and led is unchanged.
- All other CMD bytes are errors.
- FSM states: IDLE, CMD, HI, LO, END. Transitions apply only on rx_valid, except timeout.
  - IDLE: '#' goes to CMD. Every other byte is ignored silently, with no error.
  - CMD: 'L'/'H'/'T' latches cmd and goes to HI. '#' stays in CMD with no error. Other bytes are an error and go to IDLE.
  - HI: hex digit latches the high nibble and goes to LO. '#' is an error and goes to CMD (resync). Other bytes are an error and go to IDLE.
  - LO: same as HI, but latches the low nibble and goes to END.
  - END: LF/CR executes the command (or flags an error for 'T' with arg > 0x0F) and goes to IDLE. '#' is an error and goes to CMD. Other bytes are an error and go to IDLE.
- Error definition: cmd_err pulses for 1 cycle, and err_cnt increments unless it is 255.
- A CR LF pair ends the first frame on CR; the trailing LF then arrives in IDLE and is ignored.

## Timing
- rx_valid with the terminator at cycle N produces the led update, cmd_done=1 and state=IDLE, all visible at cycle N+1. cmd_done lasts exactly 1 cycle.
- cmd_err is registered with the same single-cycle latency as cmd_done. err_cnt updates in the same cycle as cmd_err.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on every rx_valid and while in IDLE; increments every cycle in any other state.
  - On reaching TIMEOUT_CYCLES-1 without rx_valid, the next cycle has cmd_err=1, state=IDLE and the counter cleared.
- rx_valid in the same cycle as timeout expiry: the byte wins and no timeout error is raised.
- cmd_done and cmd_err are never asserted together.
- Reset asserted mid-frame: state goes to IDLE immediately (asynchronously) and all outputs return to their reset values. The partial frame is lost.
- rx_data is ignored whenever rx_valid=0.

## Structure
- Shared package bt_pkg holds:
  - ASCII constants: CH_HASH, CH_LF, CH_CR, CMD_L, CMD_H, CMD_T.
  - FSM state encoding, 3-bit localparams IDLE..END.
- Sub-module bt_hex2nib: combinational. Takes an 8-bit ASCII byte and returns a 4-bit nibble plus an is_hex flag. Instantiated once and shared by the HI and LO states.
- Top level contains the FSM, cmd/argument latches, timeout counter, led register and error counter.

## Test plan
- Bytes 23 4C 41 35 0A → led=16'h00A5, then 23 48 63 33 0D → led=16'hC3A5, with one cmd_done pulse per frame and cmd_err never asserted.
- From led=0, bytes 23 54 30 37 0A → led=16'h0080; repeating the frame gives led=16'h0000. Bytes 23 54 31 30 0A → cmd_err=1, err_cnt=1, led unchanged.
- Bytes 23 4C 47 → cmd_err on the 'G' byte and state back to IDLE. Then 23 4C 23 4C 30 31 0A → one error on the second '#', then led[7:0]=01 and cmd_done.
- With TIMEOUT_CYCLES=100, send 23 4C and wait 100 cycles → cmd_err pulse at the expected cycle, err_cnt+1. A subsequent 30 31 0A is ignored in IDLE and led is unchanged.
- Drive 300 bad frames (23 5A …) → err_cnt saturates at 255. Assert reset mid-frame → led, err_cnt, cmd_done and cmd_err all 0 immediately; a full frame after reset release executes normally.
